// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between IFU and LSU: one outstanding transaction,
// LSU priority with an IFU anti-starvation limit, and a bounded response wait.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_rsp_valid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_rsp_err,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_rsp_valid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_rsp_err,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_IFU,
        REQ_LSU,
        WAIT_IFU,
        WAIT_LSU
    } state_t;

    localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [7:0]  timer_q, timer_d;
    logic        timeoutHit;
    logic        rspFire;
    logic [31:0] rspData;

    assign timeoutHit = (timer_q == TimeoutLast);
    // Responses are suppressed while reset is asserted so an abandoned transaction never completes.
    assign rspFire    = rst_n && (mem_rsp_valid || timeoutHit);
    assign rspData    = (rst_n && mem_rsp_valid) ? mem_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            streak_q <= 4'h0;
            timer_q  <= 8'h0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        timer_d       = timer_q;
        mem_req_valid = 1'b0;
        mem_addr      = 32'h0;
        mem_wen       = 1'b0;
        mem_wdata     = 32'h0;
        mem_wmask     = 4'h0;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rdata     = 32'h0;
        ifu_rsp_err   = 1'b0;
        lsu_rsp_valid = 1'b0;
        lsu_rdata     = 32'h0;
        lsu_rsp_err   = 1'b0;

        case (state_q)
            IDLE: begin
                // LSU wins ties until it has beaten a waiting IFU STARVE_LIMIT times in a row.
                if (ifu_req_valid && (!lsu_req_valid || streak_q == StarveLimit)) begin
                    state_d  = REQ_IFU;
                    streak_d = 4'h0;
                end else if (lsu_req_valid) begin
                    state_d = REQ_LSU;
                    if (ifu_req_valid && streak_q < StarveLimit) begin
                        streak_d = streak_q + 4'h1;
                    end
                end
            end
            REQ_IFU: begin
                mem_req_valid = 1'b1;
                mem_addr      = ifu_addr;
                ifu_req_ready = mem_req_ready;
                if (mem_req_ready) begin
                    state_d = WAIT_IFU;
                    timer_d = 8'h0;
                end
            end
            REQ_LSU: begin
                mem_req_valid = 1'b1;
                mem_addr      = lsu_addr;
                mem_wen       = lsu_wen;
                mem_wdata     = lsu_wdata;
                mem_wmask     = lsu_wmask;
                lsu_req_ready = mem_req_ready;
                if (mem_req_ready) begin
                    state_d = WAIT_LSU;
                    timer_d = 8'h0;
                end
            end
            WAIT_IFU: begin
                ifu_rsp_valid = rspFire;
                ifu_rdata     = rspData;
                ifu_rsp_err   = rspFire && !mem_rsp_valid;
                if (mem_rsp_valid || timeoutHit) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 8'h1;
                end
            end
            WAIT_LSU: begin
                lsu_rsp_valid = rspFire;
                lsu_rdata     = rspData;
                lsu_rsp_err   = rspFire && !mem_rsp_valid;
                if (mem_rsp_valid || timeoutHit) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 8'h1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing the single NPC memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). It accepts one transaction at a time from either requester, forwards it to the memory port with a valid/ready request handshake, routes the response back to the owner, and bounds every transaction with a response timeout. It sits between IFU/LSU and the memory model, replacing direct DPI memory access for the multi-cycle core.

## Interface
- STARVE_LIMIT, 4: consecutive LSU grants with IFU waiting before IFU is forced to win (1..15).
- TIMEOUT_CYCLES, 255: cycles in a wait state without a memory response before an error response (1..255).
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- ifu_req_valid  in  1 / ifu_req_ready  out  1 / ifu_addr  in  32: IFU read request.
- ifu_rsp_valid  out  1 / ifu_rdata  out  32 / ifu_rsp_err  out  1: IFU response, one-cycle pulse, no backpressure.
- lsu_req_valid  in  1 / lsu_req_ready  out  1 / lsu_addr  in  32 / lsu_wen  in  1 / lsu_wdata  in  32 / lsu_wmask  in  4: LSU request.
- lsu_rsp_valid  out  1 / lsu_rdata  out  32 / lsu_rsp_err  out  1: LSU response, one-cycle pulse.
- mem_req_valid  out  1 / mem_req_ready  in  1 / mem_addr  out  32 / mem_wen  out  1 / mem_wdata  out  32 / mem_wmask  out  4: memory request.
- mem_rsp_valid  in  1 / mem_rdata  in  32: memory response.

## Operation
- States: IDLE, REQ_IFU, REQ_LSU, WAIT_IFU, WAIT_LSU. Exactly one transaction outstanding.
- IDLE arbitration (registered): only IFU valid -> REQ_IFU; only LSU valid -> REQ_LSU; both valid -> REQ_LSU unless lsu_streak == STARVE_LIMIT, then REQ_IFU; none -> stay.
- lsu_streak (4 bit): +1 when LSU is granted while ifu_req_valid=1; cleared when IFU is granted; saturates at STARVE_LIMIT.
- REQ_x: mem_req_valid=1, mem_* payload driven combinationally from owner's inputs (IFU: mem_wen=0, mem_wdata=0, mem_wmask=0). x_req_ready = mem_req_ready; other requester's ready = 0. Handshake (mem_req_valid & mem_req_ready) -> WAIT_x. Requesters hold valid and payload stable until ready; no switching of owner while in REQ_x.
- WAIT_x: timeout counter (8 bit) cleared on entry, +1 per cycle. mem_rsp_valid=1 -> x_rsp_valid=1, x_rdata=mem_rdata, x_rsp_err=0 that cycle; next state IDLE. Counter reaches TIMEOUT_CYCLES-1 with no response -> x_rsp_valid=1, x_rdata=0, x_rsp_err=1; next state IDLE.
- Response and timeout in the same cycle: real response wins, err=0.
- mem_rsp_valid outside WAIT_x (including late responses after timeout) ignored; no output change.
- Writes (lsu_wen=1) still complete with an lsu_rsp_valid pulse; lsu_rdata = mem_rdata passthrough.
- Outputs not owned in a cycle: valid/ready/err = 0, data/addr = 0.

## Timing
- Reset (rst_n=0 at posedge): state IDLE, lsu_streak=0, timeout counter=0; all *_valid, *_ready, *_err, mem_wen = 0; all data/address outputs 0. Reset mid-transaction abandons it; no response is emitted; a subsequent memory response is ignored.
- Minimum transaction: request seen in IDLE cycle 0 -> mem_req_valid cycle 1 -> accepted cycle 1 if mem_req_ready -> response earliest cycle 2 -> IDLE cycle 3; next grant decided in cycle 3. Throughput: one transaction per 3 cycles minimum.
- Requester deasserting valid in REQ_x is a protocol violation; behaviour undefined.
- ifu_req_ready/lsu_req_ready combinational on mem_req_ready; mem_req_valid registered (state-decoded only).

## Test plan
- IFU only: ifu_addr=0x80000000, mem_req_ready=1, mem_rsp_valid 1 cycle after accept with 0x00000413 -> mem_req_valid in cycle 1, ifu_rsp_valid=1, ifu_rdata=0x00000413, err=0 in cycle 2, lsu_* outputs stay 0.
- Simultaneous requests with STARVE_LIMIT=4, both valid continuously: LSU granted 4 times, 5th grant to IFU, then lsu_streak=0 and LSU wins again.
- LSU store: lsu_wen=1, addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF, mem_req_ready low 3 cycles -> mem_* payload held stable, lsu_req_ready=1 only in accept cycle, ifu_req_ready=0 throughout.
- Timeout with TIMEOUT_CYCLES=8: no mem_rsp_valid -> lsu_rsp_valid=1, lsu_rsp_err=1, lsu_rdata=0 exactly 8 cycles after WAIT entry; late mem_rsp_valid afterwards ignored.
- Response coinciding with last timeout cycle -> err=0, rdata=mem_rdata.
- rst_n=0 during WAIT_IFU -> next cycle all outputs 0, state IDLE, no ifu_rsp_valid; new IFU request then serviced normally.
